// File: rtl/bcd_counter_bank_pkg.sv
// bcd_counter_bank_pkg: shared BCD constants, state encoding and nibble helper
package bcd_counter_bank_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam int MAX_DIGITS = 16;
    typedef enum logic {IDLE = 1'b0, RIPPLE = 1'b1} state_t;
    function automatic logic [BCD_W-1:0] get_nibble(input logic [BCD_W*MAX_DIGITS-1:0] v, input int i);
        return v[BCD_W*i +: BCD_W];
    endfunction
endpackage

// File: rtl/bcd_counter_bank_if.sv
// bcd_counter_bank_if: control pulses in, live/display counts and status out
interface bcd_counter_bank_if #(parameter int DIGITS = 6) ();
    logic inc_clk;
    logic ref_clk;
    logic [DIGITS-1:0] trigger;
    logic down;
    logic clear;
    logic [4*DIGITS-1:0] count_bcd;
    logic [4*DIGITS-1:0] disp_bcd;
    logic overflow;
    logic busy;
    modport master (output inc_clk, ref_clk, trigger, down, clear,
                    input count_bcd, disp_bcd, overflow, busy);
    modport slave (input inc_clk, ref_clk, trigger, down, clear,
                   output count_bcd, disp_bcd, overflow, busy);
endinterface

// File: rtl/bcd_counter_bank_digit_step.sv
// bcd_digit_step: one BCD digit plus/minus an addend of 0..2 with carry/borrow out
module bcd_digit_step
    import bcd_counter_bank_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    input  logic [1:0]       addend_i,
    input  logic             dir_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             carry_o
);
    localparam logic [4:0] BASE = 5'(BCD_MAX) + 5'd1;
    logic [4:0] d5, a5, up;
    logic dn_ok;
    // Five-bit intermediates keep d+a and d+10-a from wrapping before the decimal correction
    always_comb begin
        d5 = {1'b0, digit_i};
        a5 = {3'b0, addend_i};
        up = d5 + a5;
        dn_ok = d5 >= a5;
        carry_o = dir_i ? !dn_ok : up >= BASE;
        digit_o = 4'(dir_i ? (dn_ok ? d5 - a5 : d5 + BASE - a5) : (up >= BASE ? up - BASE : up));
    end
endmodule

// File: rtl/bcd_counter_bank.sv
// bcd_counter_bank: multi-digit BCD event counter with one-digit-per-cycle ripple and display latch
module bcd_counter_bank
    import bcd_counter_bank_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int IDX_WIDTH = 3
)
(
    input logic clk,
    input logic reset,
    bcd_counter_bank_if.slave bus
);
    localparam int W = BCD_W*DIGITS;
    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(DIGITS-1);
    state_t state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [DIGITS-1:0] mask_q, mask_d;
    logic dir_q, dir_d, carry_q, carry_d, ovf_q, ovf_d, ref_pend_q, ref_pend_d;
    logic [W-1:0] count_q, count_d, disp_q, disp_d;
    logic [BCD_W-1:0] cur_digit, new_digit;
    logic [1:0] addend;
    logic step_carry;
    assign cur_digit = get_nibble((BCD_W*MAX_DIGITS)'(count_q), int'(idx_q));
    assign addend = {1'b0, mask_q[idx_q]} + {1'b0, carry_q};
    bcd_digit_step u_step (
        .digit_i  (cur_digit),
        .addend_i (addend),
        .dir_i    (dir_q),
        .digit_o  (new_digit),
        .carry_o  (step_carry)
    );
    // Clear beats everything; otherwise start a ripple in IDLE or advance one digit in RIPPLE
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        mask_d = mask_q;
        dir_d = dir_q;
        carry_d = carry_q;
        ovf_d = ovf_q;
        ref_pend_d = ref_pend_q;
        count_d = count_q;
        disp_d = disp_q;
        if (bus.clear) begin
            count_d = '0;
            ovf_d = 1'b0;
            state_d = IDLE;
            ref_pend_d = 1'b0;
            if (bus.ref_clk || ref_pend_q) disp_d = '0;
        end else if (state_q == IDLE) begin
            if (bus.inc_clk) begin
                mask_d = bus.trigger;
                dir_d = bus.down;
                idx_d = '0;
                carry_d = 1'b0;
                state_d = RIPPLE;
            end
            if (bus.ref_clk) disp_d = count_q;
        end else begin
            count_d[BCD_W*idx_q +: BCD_W] = new_digit;
            carry_d = step_carry;
            idx_d = idx_q + 1'b1;
            if (bus.ref_clk) ref_pend_d = 1'b1;
            if (idx_q == LAST) begin
                state_d = IDLE;
                ovf_d = ovf_q | step_carry;
                if (bus.ref_clk || ref_pend_q) begin
                    disp_d = count_d;
                    ref_pend_d = 1'b0;
                end
            end
        end
    end
    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            mask_q <= '0;
            dir_q <= 1'b0;
            carry_q <= 1'b0;
            ovf_q <= 1'b0;
            ref_pend_q <= 1'b0;
            count_q <= '0;
            disp_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            mask_q <= mask_d;
            dir_q <= dir_d;
            carry_q <= carry_d;
            ovf_q <= ovf_d;
            ref_pend_q <= ref_pend_d;
            count_q <= count_d;
            disp_q <= disp_d;
        end
    end
    assign bus.count_bcd = count_q;
    assign bus.disp_bcd = disp_q;
    assign bus.overflow = ovf_q;
    assign bus.busy = state_q == RIPPLE;
endmodule

// File: doc/bcd_counter_bank.md
Name: bcd_counter_bank

Overview:
- Multi-digit BCD event counter directly downstream of the clock scaler.
- Consumes the scaler's one-cycle `inc_clk` pulse to add or subtract 10^i for each active trigger bit i.
- Consumes the scaler's `ref_clk` pulse to latch the running count into a stable display register for the output/display stage.
- Carry/borrow ripples sequentially, one digit per cycle, so the arithmetic is small and timing-friendly.

Parameters:
- DIGITS, 6, number of BCD digits. Must equal the scaler's DIGITS.
- IDX_WIDTH, 3, width of the digit index counter. Must satisfy 2^IDX_WIDTH > DIGITS.

Ports:
- clk  input  1  system clock.
- reset  input  1  system reset. One clock; reset is synchronous and active-high.
- inc_clk  input  1  one-cycle pulse from the scaler: start an add/sub operation.
- ref_clk  input  1  one-cycle pulse from the scaler: latch the count into the display register.
- trigger  input  DIGITS  digit-select vector, same signal as fed to the scaler. Bit i selects 10^i.
- down  input  1  0 = add, 1 = subtract. Sampled together with inc_clk.
- clear  input  1  synchronous count clear.
- count_bcd  output  4*DIGITS  live count. Digit i occupies bits [4i+3:4i].
- disp_bcd  output  4*DIGITS  display count, updated only by refresh.
- overflow  output  1  sticky flag: carry or borrow left the top digit.
- busy  output  1  a ripple operation is in progress.

Behaviour:
- Reset, sampled on posedge clk: count_bcd=0, disp_bcd=0, overflow=0, busy=0, state IDLE, ref_pend=0, mask=0, carry=0.
- States: IDLE, RIPPLE.
- IDLE, inc_clk=1 and clear=0:
  - mask<=trigger, dir<=down, idx<=0, carry<=0; go to RIPPLE.
  - Trigger is taken as a level. A held bit adds again on every inc_clk.
- RIPPLE, one cycle per digit, idx = 0..DIGITS-1:
  - a = mask[idx] + carry, range 0..2. d = digit[idx].
  - Up: s=d+a. If s>=10, digit<=s-10 and carry<=1; else digit<=s and carry<=0.
  - Down: if d>=a, digit<=d-a and carry<=0; else digit<=d+10-a and carry<=1.
  - At idx=DIGITS-1: if the computed carry-out is 1, set overflow<=1 (count wraps modulo 10^DIGITS). Then go to IDLE.
  - No early exit: always exactly DIGITS cycles.
- Timing:
  - inc_clk sampled in cycle T: busy=1 in cycles T+1..T+DIGITS.
  - Final count is visible from T+DIGITS+1.
  - Scaler spacing is 10 cycles, so DIGITS<=9 guarantees completion before ref_clk.
- inc_clk while busy: ignored, no queueing.
- Digit arithmetic: every digit stays in 0..9 at all times. Intermediate values use a 5-bit width.
- ref_clk:
  - In IDLE (and no clear, see below): disp_bcd<=count_bcd in the same edge, so it is visible in the next cycle.
  - While busy: set ref_pend. The latch happens on the cycle the state returns to IDLE and includes the final result; then ref_pend clears.
  - Multiple ref pulses while busy collapse into one.
- clear: highest priority after reset.
  - count_bcd<=0, overflow<=0, state<=IDLE, busy<=0.
  - Aborts any ripple; the partial result is discarded.
  - inc_clk in the same cycle is dropped.
  - ref_clk in the same cycle, or a pending ref: disp_bcd<=0 on the following cycle.
- disp_bcd changes only on refresh, clear-induced refresh, or reset. It never shows a partial ripple value.

Decomposition:
- Shared package holds:
  - BCD_W=4, BCD_MAX=9.
  - State encoding: IDLE=1'b0, RIPPLE=1'b1.
  - Function to extract a nibble from a packed BCD vector.
- Sub-module bcd_digit_step, combinational:
  - Inputs: digit, addend(0..2), dir.
  - Outputs: new digit, carry/borrow.
  - Instantiated once and muxed by idx.

Test Plan:
- Reset, then inc_clk with trigger=000001, up -> count 000001 at T+7; busy high exactly T+1..T+6; disp stays 000000 until ref_clk, then disp=000001.
- Count=099999, trigger=000001, up -> 100000 after 6 cycles; overflow=0.
- Count=999999, trigger=000011, up -> 000010; overflow=1 and stays 1 until clear.
- Count=000100, trigger=000001, down -> 000099; count=000000 down by 1 -> 999999 with overflow=1.
- ref_clk asserted at T+3 during ripple of 000009+1 -> disp shows 000010 on cycle T+7, never an intermediate value; second inc_clk at T+4 ignored.
- clear at T+2 mid-ripple with ref_clk same cycle -> count=000000, busy=0 next cycle, disp=000000, overflow=0; reset mid-ripple gives identical zeroed outputs.
